// File: rtl/savestate_ui_multi.sv
// savestate_ui_multi: keyboard/gamepad/OSD savestate front-end; ps2_key/joy*/OSD_saveload/status_slot in, ss_save/ss_load/ss_slot/ss_info*/statusUpdate/selected_slot out
module savestate_ui_multi #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_BITS = $clog2(NUM_SLOTS),
  parameter int INFO_TIMEOUT_BITS = 25,
  parameter int CONFIRM_BITS = 26,
  parameter bit WRAP = 1'b1,
  parameter bit CONFIRM_OVERWRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic                 allow_ss,
  input  logic                 joySS,
  input  logic                 joyRight,
  input  logic                 joyLeft,
  input  logic                 joyDown,
  input  logic                 joyUp,
  input  logic                 joyRewind,
  input  logic                 rewindEnable,
  input  logic [SLOT_BITS-1:0] status_slot,
  input  logic                 autoincslot,
  input  logic [1:0]           OSD_saveload,
  input  logic [NUM_SLOTS-1:0] validSStates,
  input  logic                 ss_busy,
  output logic                 ss_save,
  output logic                 ss_load,
  output logic [SLOT_BITS-1:0] ss_slot,
  output logic                 ss_info_req,
  output logic [7:0]           ss_info,
  output logic                 statusUpdate,
  output logic [SLOT_BITS-1:0] selected_slot
);
  typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;
  localparam logic [SLOT_BITS-1:0] LAST = SLOT_BITS'(NUM_SLOTS - 1);
  function automatic logic [SLOT_BITS-1:0] step(input logic [SLOT_BITS-1:0] s, input logic up);
    return up ? (s == LAST ? (WRAP ? '0 : s) : s + 1'b1)
              : (s == '0 ? (WRAP ? LAST : s) : s - 1'b1);
  endfunction
  function automatic logic [4:0] fkey(input logic [7:0] c);
    case (c)
      8'h05: return 5'h10;
      8'h06: return 5'h11;
      8'h04: return 5'h12;
      8'h0C: return 5'h13;
      8'h03: return 5'h14;
      8'h0B: return 5'h15;
      8'h83: return 5'h16;
      8'h0A: return 5'h17;
      default: return 5'h00;
    endcase
  endfunction
  state_t state_q, state_d;
  logic alt_q, alt_d, tog_q, op_q, op_d;
  logic [3:0] joy_q;
  logic [1:0] osd_q;
  logic [SLOT_BITS-1:0] stat_q, rslot_q, rslot_d, selected_slot_q, selected_slot_d, ss_slot_q, ss_slot_d;
  logic [INFO_TIMEOUT_BITS-1:0] help_q, help_d;
  logic [CONFIRM_BITS-1:0] conf_q, conf_d;
  logic ss_save_q, ss_save_d, ss_load_q, ss_load_d, ss_info_req_q, ss_info_req_d, status_update_q, status_update_d;
  logic [7:0] ss_info_q, ss_info_d;
  logic [4:0] fk;
  logic [SLOT_BITS-1:0] kb_slot, req_slot, iss_slot, stepped;
  logic kb_ev, kb_press, pad, rt, lf, dn, up_e, osv, old, schg, req_v, req_save, invalid, arm;
  logic iss, iss_save, arm_i, step_chg, help_hit, rew;
  always_comb begin
    fk = fkey(ps2_key[7:0]);
    kb_ev = ps2_key[10] != tog_q;
    kb_slot = fk[SLOT_BITS-1:0];
    kb_press = allow_ss && kb_ev && ps2_key[9] && !ps2_key[8] && fk[4] && ({1'b0, fk[3:0]} < 5'(NUM_SLOTS));
    alt_d = (kb_ev && ps2_key[7:0] == 8'h11) ? ps2_key[9] : alt_q;
    pad = allow_ss && joySS;
    rt = pad && joyRight && !joy_q[3];
    lf = pad && joyLeft && !joy_q[2];
    dn = pad && joyDown && !joy_q[1];
    up_e = pad && joyUp && !joy_q[0];
    osv = allow_ss && OSD_saveload[0] && !osd_q[0];
    old = allow_ss && OSD_saveload[1] && !osd_q[1];
    schg = allow_ss && status_slot != stat_q;
    req_v = kb_press || osv || old || dn || up_e;
    req_save = kb_press ? alt_q : (osv || old) ? osv : dn;
    req_slot = kb_press ? kb_slot : selected_slot_q;
    invalid = state_q == IDLE && req_v && !req_save && !validSStates[req_slot];
    arm = CONFIRM_OVERWRITE && req_save && !kb_press && !osv && !old && validSStates[req_slot];
    state_d = state_q;
    conf_d = conf_q;
    op_d = op_q;
    rslot_d = rslot_q;
    iss = 1'b0;
    arm_i = 1'b0;
    case (state_q)
      IDLE: if (req_v && !invalid) begin
        op_d = req_save;
        rslot_d = req_slot;
        if (arm) begin
          state_d = ARMED;
          conf_d = '1;
          arm_i = 1'b1;
        end else if (ss_busy) state_d = PENDING;
        else iss = 1'b1;
      end
      ARMED: if (!pad || up_e || conf_q == '0 || selected_slot_q != rslot_q) state_d = IDLE;
        else if (dn) begin
          state_d = ss_busy ? PENDING : IDLE;
          iss = !ss_busy;
        end else conf_d = conf_q - 1'b1;
      default: if (!ss_busy) begin
        state_d = IDLE;
        iss = 1'b1;
      end
    endcase
    iss_save = op_d;
    iss_slot = rslot_d;
    stepped = step(selected_slot_q, rt);
    step_chg = (rt || lf) && stepped != selected_slot_q;
    selected_slot_d = kb_press ? kb_slot : schg ? status_slot : (rt || lf) ? stepped :
                      (iss && iss_save && autoincslot) ? step(selected_slot_q, 1'b1) : selected_slot_q;
    status_update_d = kb_press || schg || selected_slot_d != selected_slot_q;
    help_hit = help_q[INFO_TIMEOUT_BITS-1];
    help_d = (!pad || joyRight || joyLeft || joyDown || joyUp || help_hit) ? '0 : help_q + 1'b1;
    rew = allow_ss && rewindEnable && joyRewind;
    ss_save_d = iss && iss_save;
    ss_load_d = iss && !iss_save;
    ss_slot_d = iss ? iss_slot : ss_slot_q;
    ss_info_req_d = rew || iss || invalid || arm_i || step_chg || help_hit;
    ss_info_d = rew ? 8'h50 : iss ? (iss_save ? 8'h20 : 8'h30) + 8'(iss_slot) : invalid ? 8'h51 :
                arm_i ? 8'h40 + 8'(rslot_d) : step_chg ? 8'h02 + 8'(stepped) : help_hit ? 8'h01 : ss_info_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      alt_q <= 1'b0;
      tog_q <= 1'b0;
      joy_q <= '0;
      osd_q <= '0;
      stat_q <= '0;
      help_q <= '0;
      conf_q <= '0;
      op_q <= 1'b0;
      rslot_q <= '0;
      selected_slot_q <= '0;
      ss_slot_q <= '0;
      ss_save_q <= 1'b0;
      ss_load_q <= 1'b0;
      ss_info_req_q <= 1'b0;
      ss_info_q <= '0;
      status_update_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alt_q <= alt_d;
      tog_q <= ps2_key[10];
      joy_q <= {joyRight, joyLeft, joyDown, joyUp};
      osd_q <= OSD_saveload;
      stat_q <= status_slot;
      help_q <= help_d;
      conf_q <= conf_d;
      op_q <= op_d;
      rslot_q <= rslot_d;
      selected_slot_q <= selected_slot_d;
      ss_slot_q <= ss_slot_d;
      ss_save_q <= ss_save_d;
      ss_load_q <= ss_load_d;
      ss_info_req_q <= ss_info_req_d;
      ss_info_q <= ss_info_d;
      status_update_q <= status_update_d;
    end
  end
  assign ss_save = ss_save_q;
  assign ss_load = ss_load_q;
  assign ss_slot = ss_slot_q;
  assign ss_info_req = ss_info_req_q;
  assign ss_info = ss_info_q;
  assign statusUpdate = status_update_q;
  assign selected_slot = selected_slot_q;
endmodule

// File: doc/savestate_ui_multi.md
Name: savestate_ui_multi

Overview:
- Parametrised savestate front-end for the core: turns keyboard (Alt/F-keys), gamepad combo and OSD commands into save/load requests and OSD info-text codes.
- Generalised to NUM_SLOTS slots, with optional slot wrap-around and optional overwrite confirmation.
- Holds one outstanding request and issues it to the savestate engine through an ss_busy handshake.
- Sits between the hps/OSD input logic and the savestate controller.

Parameters:
- NUM_SLOTS, 8, number of slots, 2..16.
- SLOT_BITS, $clog2(NUM_SLOTS), width of slot indices.
- INFO_TIMEOUT_BITS, 25, idle counter width for the help text while joySS is held.
- CONFIRM_BITS, 26, width of the overwrite-confirm window counter.
- WRAP, 1, 1: left/right and auto-increment wrap modulo NUM_SLOTS; 0: saturate at 0 and NUM_SLOTS-1.
- CONFIRM_OVERWRITE, 1, 1: gamepad save to a valid slot needs a second press.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- allow_ss  in  1  enables all UI input.
- joySS joyRight joyLeft joyDown joyUp  in  1 each  gamepad combo and directions.
- joyRewind rewindEnable  in  1 each  rewind-info request and its enable.
- status_slot  in  SLOT_BITS  OSD slot setting.
- autoincslot  in  1  increment slot after each issued save.
- OSD_saveload  in  2  [0] save, [1] load (rising edge).
- validSStates  in  NUM_SLOTS  per-slot "state present".
- ss_busy  in  1  savestate engine busy.
- ss_save ss_load  out  1 each  one-cycle request pulses.
- ss_slot  out  SLOT_BITS  slot of the last issued request, held until the next issue.
- ss_info_req  out  1  one-cycle pulse, ss_info valid.
- ss_info  out  8  info-text code.
- statusUpdate  out  1  pulse: selected_slot changed, write it back to OSD.
- selected_slot  out  SLOT_BITS  current slot.

Behaviour:
- Reset: all outputs 0, selected_slot 0, FSM IDLE, counters 0, alt 0, edge registers 0.
- Edge detection: joy and OSD inputs are registered every cycle. An action is recognised in cycle N (input=1, last=0). Its output pulse appears in cycle N+1.
- Keyboard: an event is a ps2_key[10] change. 0x11 updates alt.
  - F1..F8 = 05,06,04,0C,03,0B,83,0A select slots 0..7. Codes for slots >= NUM_SLOTS are ignored.
  - An F-key press sets the slot and pulses statusUpdate. Alt+press requests a save; press without Alt requests a load.
- OSD: a status_slot change sets selected_slot and pulses statusUpdate. OSD save/load edges request on selected_slot.
- Gamepad (only while joySS=1):
  - Right/Left step the slot per WRAP. A step pulses statusUpdate and info 0x02+slot.
  - Down requests a save. Up requests a load.
  - The idle counter reaching its MSB gives info 0x01 and the counter clears. Any button or joySS=0 also clears it.
- Load of an invalid slot: no request is made and info 0x51 is given.
- FSM:
  - IDLE: a save request from the gamepad, with CONFIRM_OVERWRITE=1 and the slot valid, goes to ARMED. This gives info 0x40+slot and loads the confirm counter.
  - Any other accepted request latches {op, slot}. It goes to PENDING if ss_busy=1; otherwise it is issued in the next cycle.
  - ARMED: a second Down edge before the counter expires, on the same slot, issues the save. Expiry, a slot change, joySS=0 or an Up edge returns to IDLE with no request.
  - PENDING: waits for ss_busy=0 and issues in that cycle+1, then returns to IDLE. New requests while PENDING are dropped.
- Issue:
  - The request pulses ss_save or ss_load, sets ss_slot, and gives info 0x20+slot (save) or 0x30+slot (load).
  - On a save with autoincslot=1, selected_slot advances per WRAP and statusUpdate pulses.
- Rewind: rewindEnable&joyRewind gives info 0x50 every cycle.
- Info priority in the same cycle: rewind > issue > invalid/confirm > slot step > help.
- Simultaneous requests: keyboard > OSD > gamepad; only one request is accepted per cycle.
- allow_ss=0:
  - Input edges are ignored and ARMED returns to IDLE.
  - PENDING still issues.
  - Edge registers keep tracking, so no spurious edge fires when allow_ss returns.
- Reset mid-PENDING: the request is discarded and no pulse occurs.

Test Plan:
- NUM_SLOTS=8, WRAP=1, slot 7, joySS+Right edge -> selected_slot=0, statusUpdate and ss_info_req pulse, ss_info=0x02.
- WRAP=0, slot 7, Right -> no change, no pulse. Slot 0, Left -> no change.
- Alt+F3 with ss_busy=1 for 10 cycles -> no pulse while busy. ss_save is asserted one cycle after busy falls, ss_slot=2, ss_info=0x22.
- validSStates[4]=1, slot 4, joySS+Down -> ARMED, info 0x44. Second Down within window -> ss_save, info 0x24. Repeat with no second press -> window expires, no ss_save.
- F5 without Alt, validSStates[4]=0 -> no ss_load, info 0x51. Then valid=1 -> ss_load, ss_slot=4, info 0x34.
- autoincslot=1, slot 3, OSD_saveload[0] edge -> ss_save on slot 3, then selected_slot=4 with a statusUpdate pulse. Reset asserted during PENDING -> all outputs 0 and no later pulse.
